// File: rtl/dlv2_rx.sv
// Receive-side inverse of the two-phase lane delay: re-pairs each even half with the
// odd half sent one valid word earlier and re-interleaves the bits into the original word.
module dlv2_rx #(
    parameter int unsigned WIDTH = 40
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             resync,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             primed,
    output logic [15:0]      drop_cnt
);

    localparam int unsigned H     = WIDTH / 2;
    localparam int unsigned CNT_W = 16;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    // The half-word split only makes sense for even widths of at least two bit pairs.
    generate
        if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("dlv2_rx: WIDTH must be even and >= 4");
        end
    endgenerate

    logic [0:0]       state_q, state_d;
    logic [H-1:0]     odd_q, odd_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             primed_q, primed_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [WIDTH-1:0] woven_c;

    // Even half of the incoming word lands on even bit positions, held odd half on odd ones.
    for (genvar i = 0; i < H; i++) begin : g_weave
        assign woven_c[2*i]   = din[i];
        assign woven_c[2*i+1] = odd_q[i];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= ST_EMPTY;
            odd_q    <= '0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
            primed_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            odd_q    <= odd_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
            primed_q <= primed_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        odd_d   = odd_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        drop_d  = drop_q;

        if (resync) begin
            // Any word arriving alongside resync is discarded without counting it as a drop.
            state_d = ST_EMPTY;
            odd_d   = '0;
        end else if (din_valid) begin
            case (state_q)
                ST_EMPTY: begin
                    // Even half belongs to a word from before the stream start.
                    odd_d   = din[WIDTH-1:H];
                    state_d = ST_HOLD;
                    drop_d  = (drop_q == {CNT_W{1'b1}}) ? drop_q : drop_q + CNT_W'(1);
                end
                ST_HOLD: begin
                    dout_d  = woven_c;
                    dv_d    = 1'b1;
                    odd_d   = din[WIDTH-1:H];
                end
                default: begin
                    state_d = ST_EMPTY;
                    odd_d   = '0;
                end
            endcase
        end

        primed_d = (state_d == ST_HOLD);
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign primed     = primed_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_dlv2_rx.sv
// Bench for dlv2_rx: directed 8-bit vectors plus a 40-bit round trip through a forward-delay model.
module tb_dlv2_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic        resync8, v8, dv8, pr8;
    logic [7:0]  din8, dout8;
    logic [15:0] dc8;
    logic        resync40, v40, dv40, pr40;
    logic [39:0] din40, dout40;
    logic [15:0] dc40;

    int checks   = 0;
    int failures = 0;

    dlv2_rx #(.WIDTH(8)) u8 (
        .clk(clk), .arst_n(arst_n), .resync(resync8), .din(din8), .din_valid(v8),
        .dout(dout8), .dout_valid(dv8), .primed(pr8), .drop_cnt(dc8)
    );

    dlv2_rx #(.WIDTH(40)) u40 (
        .clk(clk), .arst_n(arst_n), .resync(resync40), .din(din40), .din_valid(v40),
        .dout(dout40), .dout_valid(dv40), .primed(pr40), .drop_cnt(dc40)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] weave(input logic [19:0] odd, input logic [19:0] even, input int h);
        logic [39:0] w = '0;
        for (int i = 0; i < h; i++) begin
            w[2*i]   = even[i];
            w[2*i+1] = odd[i];
        end
        return w;
    endfunction

    function automatic logic [19:0] odd_of(input logic [39:0] w, input int h);
        logic [19:0] r = '0;
        for (int i = 0; i < h; i++) r[i] = w[2*i+1];
        return r;
    endfunction

    function automatic logic [19:0] even_of(input logic [39:0] w, input int h);
        logic [19:0] r = '0;
        for (int i = 0; i < h; i++) r[i] = w[2*i];
        return r;
    endfunction

    // Word-level model: 8-bit side re-pairs accepted words, 40-bit side replays the sent originals.
    logic        m8_in, m8_dv;
    logic [7:0]  m8_prev, m8_dout;
    logic [15:0] m8_drop;
    logic        m40_in, m40_dv;
    logic [39:0] m40_dout;
    logic [15:0] m40_drop;
    logic [39:0] sent_q[$];
    logic        preset8 = 1'b0;
    logic        hold_cmp = 1'b0;
    int          pulses8 = 0;
    int          out40 = 0;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m8_in = 1'b0; m8_dv = 1'b0; m8_prev = '0; m8_dout = '0; m8_drop = '0;
            m40_in = 1'b0; m40_dv = 1'b0; m40_dout = '0; m40_drop = '0;
        end else begin
            if (preset8) m8_drop = 16'hFFFB;
            m8_dv = 1'b0;
            if (resync8) begin
                m8_in = 1'b0;
            end else if (v8) begin
                if (!m8_in) begin
                    m8_in = 1'b1;
                    if (m8_drop != 16'hFFFF) m8_drop = m8_drop + 16'd1;
                end else begin
                    m8_dout = 8'(weave({16'd0, m8_prev[7:4]}, {16'd0, din8[3:0]}, 4));
                    m8_dv   = 1'b1;
                end
                m8_prev = din8;
            end
            m40_dv = 1'b0;
            if (v40 && !resync40) begin
                if (!m40_in) begin
                    m40_in = 1'b1;
                    if (m40_drop != 16'hFFFF) m40_drop = m40_drop + 16'd1;
                end else if (sent_q.size() > 0) begin
                    m40_dout = sent_q.pop_front();
                    m40_dv   = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (arst_n && !hold_cmp) begin
            check("dv8", 64'(dv8), 64'(m8_dv));
            check("primed8", 64'(pr8), 64'(m8_in));
            check("drop8", 64'(dc8), 64'(m8_drop));
            check("dout8", 64'(dout8), 64'(m8_dout));
            check("dv40", 64'(dv40), 64'(m40_dv));
            check("primed40", 64'(pr40), 64'(m40_in));
            check("drop40", 64'(dc40), 64'(m40_drop));
            check("dout40", 64'(dout40), 64'(m40_dout));
            if (dv8) pulses8++;
            if (dv40) out40++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send8(input logic [7:0] d);
        din8 = d;
        v8   = 1'b1;
        tick(1);
        v8   = 1'b0;
    endtask

    task automatic resync_pulse8();
        resync8 = 1'b1;
        tick(1);
        resync8 = 1'b0;
    endtask

    initial begin
        logic [39:0] w;
        logic [19:0] tx_even, oh;
        int p0;

        arst_n = 1'b0; resync8 = 1'b0; v8 = 1'b0; din8 = '0;
        resync40 = 1'b0; v40 = 1'b0; din40 = '0;
        #12;
        check("rst_dout8", 64'(dout8), 64'h0);
        check("rst_dv8", 64'(dv8), 64'h0);
        check("rst_primed8", 64'(pr8), 64'h0);
        check("rst_drop8", 64'(dc8), 64'h0);
        @(negedge clk);
        arst_n = 1'b1;
        tick(1);

        // Basic re-pair: C0 then 63 restores A5.
        send8(8'hC0);
        check("basic_prime_dv", 64'(dv8), 64'h0);
        check("basic_primed", 64'(pr8), 64'h1);
        check("basic_drop", 64'(dc8), 64'h1);
        send8(8'h63);
        check("basic_dout", 64'(dout8), 64'hA5);
        check("basic_dv", 64'(dv8), 64'h1);
        tick(1);
        check("basic_dv_after", 64'(dv8), 64'h0);

        // Valid gap is transparent.
        resync_pulse8();
        p0 = pulses8;
        send8(8'hC0);
        for (int g = 0; g < 5; g++) begin
            tick(1);
            check("gap_dv", 64'(dv8), 64'h0);
        end
        send8(8'h63);
        check("gap_dout", 64'(dout8), 64'hA5);
        check("gap_dv_hi", 64'(dv8), 64'h1);
        tick(3);
        check("gap_pulses", 64'(pulses8 - p0), 64'h1);
        check("gap_drop", 64'(dc8), 64'h2);

        // Resync collides with a valid word.
        resync8 = 1'b1; din8 = 8'h63; v8 = 1'b1;
        tick(1);
        resync8 = 1'b0; v8 = 1'b0;
        check("coll_dv", 64'(dv8), 64'h0);
        check("coll_primed", 64'(pr8), 64'h0);
        check("coll_drop", 64'(dc8), 64'h2);
        send8(8'hC0);
        check("coll_reprime", 64'(pr8), 64'h1);
        check("coll_drop_inc", 64'(dc8), 64'h3);
        send8(8'h63);
        check("coll_dout", 64'(dout8), 64'hA5);

        // Async reset off-edge while dout_valid is high.
        #2 arst_n = 1'b0;
        #1;
        check("arst_dout", 64'(dout8), 64'h0);
        check("arst_dv", 64'(dv8), 64'h0);
        check("arst_primed", 64'(pr8), 64'h0);
        check("arst_drop", 64'(dc8), 64'h0);
        @(negedge clk);
        arst_n = 1'b1;
        tick(1);
        send8(8'h63);
        check("post_rst_dv", 64'(dv8), 64'h0);
        check("post_rst_drop", 64'(dc8), 64'h1);
        send8(8'hC0);
        check("post_rst_dout", 64'(dout8), 64'h28);
        check("post_rst_dv2", 64'(dv8), 64'h1);

        // Saturation: preload the counter near the top, then keep re-priming.
        resync_pulse8();
        hold_cmp = 1'b1;
        preset8  = 1'b1;
        force u8.drop_q = 16'hFFFB;
        tick(1);
        release u8.drop_q;
        preset8  = 1'b0;
        hold_cmp = 1'b0;
        check("sat_preload", 64'(dc8), 64'hFFFB);
        for (int k = 0; k < 8; k++) begin
            send8(8'h5A);
            resync_pulse8();
        end
        check("sat_hold", 64'(dc8), 64'hFFFF);

        // Round trip at WIDTH=40 from a clean reset.
        #2 arst_n = 1'b0;
        #3 arst_n = 1'b1;
        tick(1);
        out40 = 0;
        tx_even = '0;
        for (int n = 0; n < 10000; n++) begin
            w  = 40'({$urandom, $urandom});
            oh = odd_of(w, 20);
            din40 = {oh, tx_even};
            sent_q.push_back(w);
            v40 = 1'b1;
            tick(1);
            v40 = 1'b0;
            tx_even = even_of(w, 20);
            tick($urandom_range(0, 2));
        end
        tick(3);
        check("rt_count", 64'(out40), 64'd9999);
        check("rt_drop", 64'(dc40), 64'h1);
        check("rt_primed", 64'(pr40), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dlv2_rx.md
Name: dlv2_rx

Overview:
- Receive-side inverse of the two-phase lane delay used on the SL3 user-control / FEC halt path.
- The transmit side splits each WIDTH-bit word into odd-index and even-index halves. It sends the odd half of word t together with the even half of word t-1.
- This block re-pairs each even half with the odd half sent one word earlier and re-interleaves the bits, so the original word order is restored.
- It sits directly after the lane datapath, ahead of FEC check / halt decode. It handles valid gaps, stream start (priming) and explicit resync.

Parameters:
- WIDTH, 40, word width in bits. Must be even and ≥ 4; an odd WIDTH is an elaboration error.
- H (localparam), WIDTH/2, half-word width.

Ports:
- clk  in  1  single clock for all logic
- arst_n  in  1  asynchronous active-low reset
- resync  in  1  synchronous restart: discards the held half and returns to EMPTY
- din  in  WIDTH  {odd half of word t, even half of word t-1}
  - odd half: din[WIDTH-1:H]
  - even half: din[H-1:0]
- din_valid  in  1  din qualifier; no backpressure
- dout  out  WIDTH  restored original word
- dout_valid  out  1  dout qualifier, one cycle per word
- primed  out  1  high while an odd half is held (state HOLD)
- drop_cnt  out  16  count of discarded even halves, saturating

Behaviour:
- Half-word packing:
  - Odd half bit i carries original bit 2i+1.
  - Even half bit i carries original bit 2i.
- Reset (arst_n low, asynchronous):
  - state = EMPTY; odd_reg = 0.
  - dout = 0, dout_valid = 0, primed = 0, drop_cnt = 0.
  - All outputs are registered.
- States: EMPTY, HOLD.
- EMPTY, din_valid = 1:
  - odd_reg <= din[WIDTH-1:H].
  - The even half belongs to a word before the stream start, so it is discarded; drop_cnt += 1.
  - Go to HOLD. dout_valid <= 0.
- HOLD, din_valid = 1:
  - dout[2i] <= din[i] and dout[2i+1] <= odd_reg[i], for i = 0..H-1.
  - dout_valid <= 1.
  - odd_reg <= din[WIDTH-1:H]. Stay in HOLD.
- din_valid = 0 in any state:
  - odd_reg and state hold; dout_valid <= 0; dout holds its last value.
  - Gaps of any length are transparent. The pairing is by valid words, not by cycles.
- Latency: word t is presented on dout in the cycle after the edge that accepts input word t+1.
  - With back-to-back valids this is 1 cycle after the odd half arrived, plus the output register.
  - The final word of a stream stays in odd_reg until the next valid word or a resync.
- resync = 1 (synchronous, has priority over din_valid):
  - state <= EMPTY; odd_reg <= 0; dout_valid <= 0.
  - A simultaneous din word is dropped entirely; drop_cnt is not incremented.
  - The next valid word after resync primes again.
- drop_cnt: increments only on the EMPTY + valid + no-resync case. It saturates at 16'hFFFF and does not wrap.
- primed = (state == HOLD), registered.
- Reset asserted mid-stream: the held odd half is lost. After release the block behaves as at power-up, so the first valid word is a priming word.
- Pure streaming: no ready signal; one word in per valid cycle, one word out at most per cycle.
- Round-trip property: forward transform (with its even register initialised to 0) followed by this block reproduces the input sequence delayed by one word; the first transmitted word is consumed as priming.

Test Plan (WIDTH = 8 unless noted):
- Basic re-pair: after reset, din_valid=1 with din=8'hC0 then 8'h63 on consecutive cycles.
  - First word: no dout_valid; primed=1; drop_cnt=1.
  - Second word: next cycle dout=8'hA5, dout_valid=1.
- Valid gap: din=C0, then 5 idle cycles, then 63.
  - dout_valid stays low through the gap.
  - The cycle after 63 is accepted, dout=A5 with dout_valid=1.
  - No extra dout_valid pulses occur.
- Resync collision: primed, then resync=1 together with din_valid=1, din=63.
  - dout_valid=0; state EMPTY; drop_cnt unchanged.
  - Next valid word re-primes and drop_cnt increments.
- Async reset mid-stream: arst_n low between two valid words, asserted off-edge.
  - All outputs go to 0 immediately.
  - After release, the first valid word produces no output.
- Round trip, WIDTH=40: 10,000 random words with random valid gaps, passed through the forward delay model and then dlv2_rx.
  - Output equals the input sequence shifted by one word, bit-exact.
  - drop_cnt=1.
- Saturation: force 70,000 resync/valid alternations.
  - drop_cnt stops at 16'hFFFF and does not wrap.
